// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD constants, FSM state type and CRC7 step function
package sd_pkg;

    localparam logic [6:0] CRC7_POLY        = 7'h09;
    localparam int         SD_FRAME_W       = 48;
    localparam int         SD_PREAMBLE_CLKS = 80;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD17 = 6'd17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SHIFT,
        ST_FINISH
    } sd_state_e;

    // One MSB-first step of x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_cmd_tx_if.sv
// rtl/sd_cmd_tx_if.sv - command request/status interface of the SD command transmitter
interface sd_cmd_tx_if;

    logic        start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        ready;
    logic        done;
    logic [6:0]  crc7;

    modport master (
        output start, cmd_index, cmd_arg,
        input  ready, done, crc7
    );

    modport slave (
        input  start, cmd_index, cmd_arg,
        output ready, done, crc7
    );

endinterface

// File: rtl/crc7_serial.sv
// rtl/crc7_serial.sv - bit-serial CRC7 register, shared by command TX and response checking
module crc7_serial
    import sd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_bit,
    output logic [6:0] o_crc
);

    logic [6:0] r_crc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_crc <= '0;
        end else if (i_clear) begin
            r_crc <= '0;
        end else if (i_enable) begin
            r_crc <= crc7_step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sd_cmd_tx.sv
// rtl/sd_cmd_tx.sv - SD command frame serializer with on-the-fly CRC7; SD_CMD_TX_PREAMBLE_EN adds the 80-clock power-up preamble
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int DIV = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    sd_cmd_tx_if.slave  s_req,
    output logic        o_sd_clk,
    output logic        o_sd_cmd
);

    localparam int                DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
`ifdef SD_CMD_TX_PREAMBLE_EN
    localparam sd_state_e         RESET_STATE = ST_PREAMBLE;
`else
    localparam sd_state_e         RESET_STATE = ST_IDLE;
`endif

    sd_state_e          r_state;
    sd_state_e          w_state_next;
    logic [DIV_W-1:0]   r_div_cnt;
    logic               r_sd_clk;
    logic [47:0]        r_frame;
    logic [5:0]         r_bit_cnt;
    logic [6:0]         r_crc_shadow;
    logic [6:0]         w_crc;
    logic               w_run;
    logic               w_bit_end;
    logic               w_accept;
    logic               w_ready;
    logic               w_done;
    logic               w_crc_en;
    logic               w_crc_bit;
    logic               w_in_crc_field;
    logic               w_pre_last;

    assign w_run     = (r_state == ST_SHIFT) || (r_state == ST_PREAMBLE);
    // A bit (or preamble clock) ends on the last cycle of the SD_CLK high half.
    assign w_bit_end = w_run && r_sd_clk && (r_div_cnt == DIV_LAST);

`ifdef SD_CMD_TX_PREAMBLE_EN
    logic [6:0] r_pre_cnt;

    assign w_pre_last = (r_pre_cnt == 7'(SD_PREAMBLE_CLKS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pre_cnt <= '0;
        end else if ((r_state == ST_PREAMBLE) && w_bit_end) begin
            r_pre_cnt <= r_pre_cnt + 7'd1;
        end
    end
`else
    assign w_pre_last = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (s_req.start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_PREAMBLE: begin
                if (w_bit_end && w_pre_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_bit_end && (r_bit_cnt == 6'd0)) begin
                    w_state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_ready = 1'b1;
                w_done  = 1'b1;
                if (s_req.start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = RESET_STATE;
        endcase
    end

    // Divider restarts from the low half whenever the line is not being clocked.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
            r_sd_clk  <= 1'b0;
        end else if (w_run) begin
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= '0;
                r_sd_clk  <= ~r_sd_clk;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end else begin
            r_div_cnt <= '0;
            r_sd_clk  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_frame   <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_frame   <= {1'b0, 1'b1, s_req.cmd_index, s_req.cmd_arg, 7'b0, 1'b1};
            r_bit_cnt <= 6'(SD_FRAME_W - 1);
        end else if ((r_state == ST_SHIFT) && w_bit_end) begin
            r_frame   <= {r_frame[46:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 6'd1;
        end
    end

    // Over bits 7..1 the CRC register is fed its own MSB, which reduces to a plain left shift.
    assign w_in_crc_field = (r_bit_cnt != 6'd0) && (r_bit_cnt < 6'd8);
    assign w_crc_bit      = w_in_crc_field ? w_crc[6] : r_frame[47];
    assign w_crc_en       = (r_state == ST_SHIFT) && w_bit_end && (r_bit_cnt != 6'd0);

    crc7_serial u_crc7 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_accept),
        .i_enable (w_crc_en),
        .i_bit    (w_crc_bit),
        .o_crc    (w_crc)
    );

    // Capture the finished CRC on the first cycle of bit 7, before shifting destroys it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_crc_shadow <= '0;
        end else if ((r_state == ST_SHIFT) && (r_bit_cnt == 6'd7) && !r_sd_clk
                     && (r_div_cnt == '0)) begin
            r_crc_shadow <= w_crc;
        end
    end

    assign o_sd_clk    = r_sd_clk;
    assign o_sd_cmd    = (r_state == ST_SHIFT) ? w_crc_bit : 1'b1;
    assign s_req.ready = w_ready;
    assign s_req.done  = w_done;
    assign s_req.crc7  = r_crc_shadow;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// tb/tb_sd_cmd_tx.sv - directed self-checking bench for sd_cmd_tx
module tb_sd_cmd_tx;
    import sd_pkg::*;

`ifdef SD_CMD_TX_PREAMBLE_EN
    localparam int TB_DIV = 1;
    localparam bit PRE    = 1'b1;
`else
    localparam int TB_DIV = 2;
    localparam bit PRE    = 1'b0;
`endif
    localparam int FRAME_CYC = 96 * TB_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sd_clk;
    logic sd_cmd;

    sd_cmd_tx_if u_if ();

    sd_cmd_tx #(.DIV(TB_DIV)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .s_req    (u_if),
        .o_sd_clk (sd_clk),
        .o_sd_cmd (sd_cmd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] stream        = '0;
    logic [63:0] cap_stream    = '0;
    int          nbits         = 0;
    int          cap_nbits     = 0;
    int          done_cnt      = 0;
    int          last_done_cyc = 0;
    logic        prev_clk      = 1'b0;

    // Card-side view: sample SD_CMD on each SD_CLK rising edge, capture a frame at DONE.
    always @(negedge clk) begin
        if (u_if.done) begin
            done_cnt      = done_cnt + 1;
            last_done_cyc = cyc;
            cap_stream    = stream;
            cap_nbits     = nbits;
            stream        = '0;
            nbits         = 0;
        end else if (!rst_n || u_if.ready) begin
            stream = '0;
            nbits  = 0;
        end else if (sd_clk && !prev_clk) begin
            stream = {stream[62:0], sd_cmd};
            nbits  = nbits + 1;
        end
        prev_clk = sd_clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic start_frame(input logic [5:0] idx, input logic [31:0] arg, output int t_acc);
        int k;
        @(posedge clk); #1;
        u_if.start     = 1'b1;
        u_if.cmd_index = idx;
        u_if.cmd_arg   = arg;
        k = 0;
        while (!u_if.ready && k < 400 * TB_DIV) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 400 * TB_DIV) check("ready_wait", 64'(u_if.ready), 64'd1);
        @(posedge clk); #1;
        t_acc          = cyc;
        u_if.start     = 1'b0;
        u_if.cmd_index = 6'h3F;
        u_if.cmd_arg   = 32'hDEADBEEF;
    endtask

    task automatic wait_done(input int n0);
        int k;
        k = 0;
        while (done_cnt == n0 && k < 200 * TB_DIV) begin
            @(negedge clk); #1;
            k++;
        end
    endtask

    task automatic wait_bits(input int n);
        int k;
        k = 0;
        while (nbits < n && k < 200 * TB_DIV) begin
            @(negedge clk); #1;
            k++;
        end
        check("bit_wait", 64'(nbits), 64'(n));
    endtask

    task automatic run_frame(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                             input logic [47:0] exp_stream, input logic [6:0] exp_crc);
        int t;
        int n0;
        n0 = done_cnt;
        start_frame(idx, arg, t);
        wait_done(n0);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(n0 + 1));
        check({tag, "_nbits"}, 64'(cap_nbits), 64'd48);
        check({tag, "_stream"}, cap_stream, 64'(exp_stream));
        check({tag, "_crc7"}, 64'(u_if.crc7), 64'(exp_crc));
        check({tag, "_latency"}, 64'(last_done_cyc - t), 64'(FRAME_CYC));
    endtask

    initial begin
        int t;
        int n0;
        int d1;
        logic [63:0] s1;

        u_if.start     = 1'b0;
        u_if.cmd_index = '0;
        u_if.cmd_arg   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_ready", 64'(u_if.ready), PRE ? 64'd0 : 64'd1);
        check("rst_done", 64'(u_if.done), 64'd0);
        check("rst_sd_clk", 64'(sd_clk), 64'd0);
        check("rst_sd_cmd", 64'(sd_cmd), 64'd1);
        check("rst_crc7", 64'(u_if.crc7), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef SD_CMD_TX_PREAMBLE_EN
        begin
            int rises;
            int k;
            logic ones;
            logic prev;
            rises = 0;
            ones  = 1'b1;
            prev  = 1'b0;
            k     = 0;
            while (!u_if.ready && k < 400) begin
                @(negedge clk); #1;
                if (sd_clk && !prev) begin
                    rises++;
                    if (!sd_cmd) ones = 1'b0;
                end
                prev = sd_clk;
                k++;
            end
            check("pre_rises", 64'(rises), 64'd80);
            check("pre_cmd_high", 64'(ones), 64'd1);
            check("pre_ready", 64'(u_if.ready), 64'd1);
            check("pre_no_done", 64'(done_cnt), 64'd0);
        end
`endif

        run_frame("cmd0", CMD0, 32'h00000000, 48'h400000000095, 7'h4A);
        run_frame("cmd8", CMD8, 32'h000001AA, 48'h48000001AA87, 7'h43);
        run_frame("cmd17", CMD17, 32'h00000000, 48'h510000000055, 7'h2A);

        // START while busy: ignored, not queued.
        n0 = done_cnt;
        start_frame(CMD0, 32'h00000000, t);
        wait_bits(28);
        @(posedge clk); #1;
        u_if.start     = 1'b1;
        u_if.cmd_index = CMD17;
        @(posedge clk); #1;
        u_if.start     = 1'b0;
        wait_done(n0);
        check("busy_stream", cap_stream, 64'h400000000095);
        check("busy_crc7", 64'(u_if.crc7), 64'h4A);
        check("busy_latency", 64'(last_done_cyc - t), 64'(FRAME_CYC));
        repeat (150 * TB_DIV) @(posedge clk);
        @(negedge clk); #1;
        check("busy_one_done", 64'(done_cnt), 64'(n0 + 1));
        check("busy_idle_ready", 64'(u_if.ready), 64'd1);
        check("busy_idle_sd_clk", 64'(sd_clk), 64'd0);

        // Reset pulse in the middle of a frame.
        n0 = done_cnt;
        start_frame(CMD8, 32'h000001AA, t);
        wait_bits(18);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_sd_cmd", 64'(sd_cmd), 64'd1);
        check("mid_rst_sd_clk", 64'(sd_clk), 64'd0);
        check("mid_rst_ready", 64'(u_if.ready), PRE ? 64'd0 : 64'd1);
        check("mid_rst_done", 64'(u_if.done), 64'd0);
        check("mid_rst_crc7", 64'(u_if.crc7), 64'd0);
        repeat (200 * TB_DIV) @(posedge clk);
        @(negedge clk); #1;
        check("mid_rst_no_done", 64'(done_cnt), 64'(n0));
        run_frame("post_rst_cmd0", CMD0, 32'h00000000, 48'h400000000095, 7'h4A);

`ifdef SD_CMD_TX_PREAMBLE_EN
        // Back-to-back: START held through FINISH.
        begin
            int k;
            n0 = done_cnt;
            @(posedge clk); #1;
            u_if.start     = 1'b1;
            u_if.cmd_index = CMD0;
            u_if.cmd_arg   = 32'h00000000;
            k = 0;
            while (done_cnt == n0 && k < 300) begin
                @(negedge clk); #1;
                k++;
            end
            s1 = cap_stream;
            d1 = last_done_cyc;
            @(posedge clk); #1;
            u_if.start     = 1'b0;
            u_if.cmd_index = 6'h3F;
            u_if.cmd_arg   = 32'hDEADBEEF;
            wait_done(n0 + 1);
            check("b2b_first", s1, 64'h400000000095);
            check("b2b_second", cap_stream, 64'h400000000095);
            check("b2b_gap", 64'(last_done_cyc - d1), 64'(FRAME_CYC + 1));
            check("b2b_done_cnt", 64'(done_cnt), 64'(n0 + 2));
            check("b2b_crc7", 64'(u_if.crc7), 64'h4A);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
